// File: rtl/moisture_sensor_frontend.sv
// -----------------------------------------------------------------------------
// moisture_sensor_frontend
//
// Producer end of the 4-bit soil-moisture bus read by the irrigation
// controller. Every SAMPLE_PERIOD clocks (while enabled) it runs one serial
// conversion of an external ADC (cs_n / sclk / miso, MSB first). It averages
// 2^AVG_LOG2 conversions and publishes the top four bits of the mean as the
// moisture code, together with a one-cycle valid strobe. Until the first full
// average exists the code is held at 4'hF ("wet"), so the pump never starts on
// reset garbage.
//
// Conversion sequence (one pass through the FSM):
//   IDLE  -> START  cs_n low, sclk low, CLK_DIV cycles
//         -> SHIFT  ADC_BITS sclk periods, miso captured on each 0->1 edge
//         -> STOP   cs_n high, sclk low, CLK_DIV cycles
//         -> ACCUM  one cycle: fold the sample into the running sum
//   Total 2*CLK_DIV*(ADC_BITS+1)+1 cycles; cs_n low 2*CLK_DIV*ADC_BITS+CLK_DIV.
//
// Parameters:
//   CLK_DIV        clk cycles per sclk half-period (>= 1)
//   ADC_BITS       bits per ADC conversion (>= 4)
//   AVG_LOG2       log2 of conversions averaged per code (0..4)
//   SAMPLE_PERIOD  clk cycles between conversion starts;
//                  must be >= 2*CLK_DIV*(ADC_BITS+1)+2
//
// Ports:
//   clk           in   system clock
//   reset         in   asynchronous, active-low reset
//   enable        in   1 = run periodic conversions
//   adc_miso      in   serial data from the ADC (synchronous to clk)
//   adc_cs_n      out  ADC chip select, active low
//   adc_sclk      out  ADC serial clock, idles low
//   sensor[3:0]   out  averaged moisture code, held between updates
//   sensor_valid  out  one-cycle pulse in the cycle sensor takes a new value
//   busy          out  high from START through ACCUM
// -----------------------------------------------------------------------------
module moisture_sensor_frontend #(
    parameter int CLK_DIV       = 4,
    parameter int ADC_BITS      = 8,
    parameter int AVG_LOG2      = 2,
    parameter int SAMPLE_PERIOD = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       adc_miso,
    output logic       adc_cs_n,
    output logic       adc_sclk,
    output logic [3:0] sensor,
    output logic       sensor_valid,
    output logic       busy
);

    // ------------------------------------------------------------------------
    // Derived widths and terminal counts
    // ------------------------------------------------------------------------
    localparam int ACC_W       = ADC_BITS + AVG_LOG2;         // sum of all samples fits
    localparam int CNT_W       = AVG_LOG2 + 1;                // never zero width
    localparam int DIV_W       = $clog2(CLK_DIV + 1);
    localparam int BIT_W       = $clog2(ADC_BITS);
    localparam int PER_W       = $clog2(SAMPLE_PERIOD + 1);
    localparam int NUM_SAMPLES = 1 << AVG_LOG2;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(ADC_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_SAMPLES - 1);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(SAMPLE_PERIOD - 1);

    // ------------------------------------------------------------------------
    // FSM state encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_ACCUM = 3'd4;

    logic [2:0]          state;
    logic [2:0]          state_next;
    logic [PER_W-1:0]    period_cnt;
    logic [DIV_W-1:0]    div_cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [ADC_BITS-1:0] shift_reg;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_sum;
    logic [CNT_W-1:0]    sample_cnt;

    logic start_req;
    logic div_done;
    logic sclk_rise;
    logic sclk_fall;
    logic bit_last;
    logic avg_done;

    // ------------------------------------------------------------------------
    // Period counter: parked at 0 while disabled, so a (re-)enable starts a
    // conversion on the very next cycle.
    // ------------------------------------------------------------------------
    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge value of every other flop, independent of block order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            period_cnt <= '0;
        end else if (!enable || period_cnt == PER_LAST) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + PER_W'(1);
        end
    end

    // A tick that lands while a conversion is still running is simply lost;
    // it is never remembered for later.
    assign start_req = enable && (period_cnt == '0) && (state == ST_IDLE);

    // ------------------------------------------------------------------------
    // Phase timing helpers
    // ------------------------------------------------------------------------
    assign div_done  = (div_cnt == DIV_LAST);
    assign sclk_rise = (state == ST_SHIFT) && div_done && !adc_sclk;
    assign sclk_fall = (state == ST_SHIFT) && div_done &&  adc_sclk;
    assign bit_last  = (bit_cnt == BIT_LAST);
    assign avg_done  = (sample_cnt == CNT_LAST);
    assign acc_sum   = acc + ACC_W'(shift_reg);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned; that keeps this block purely combinational (no latch).
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start_req)             state_next = ST_START;
            ST_START: if (div_done)              state_next = ST_SHIFT;
            ST_SHIFT: if (sclk_fall && bit_last) state_next = ST_STOP;
            ST_STOP:  if (div_done)              state_next = ST_ACCUM;
            ST_ACCUM:                            state_next = ST_IDLE;
            default:                             state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign busy = (state != ST_IDLE);

    // ------------------------------------------------------------------------
    // Half-period divider. Restarts on every state change so each timed phase
    // (START, each sclk half, STOP) lasts exactly CLK_DIV cycles.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (state_next != state || div_done) begin
            div_cnt <= '0;
        end else if (state == ST_START || state == ST_SHIFT || state == ST_STOP) begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Serial clock, bit counter and capture shift register.
    // miso is sampled on the same clk edge that drives sclk 0->1, giving the
    // ADC a full low half-period to present each bit.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            adc_sclk  <= 1'b0;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            if (state == ST_START) begin
                bit_cnt <= '0;
            end
            if (sclk_rise) begin
                adc_sclk  <= 1'b1;
                shift_reg <= {shift_reg[ADC_BITS-2:0], adc_miso};
            end
            if (sclk_fall) begin
                adc_sclk <= 1'b0;
                if (!bit_last) begin
                    bit_cnt <= bit_cnt + BIT_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Chip select, registered from the next state so the pin is glitch-free
    // and goes high asynchronously on reset.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            adc_cs_n <= 1'b1;
        end else begin
            adc_cs_n <= !(state_next == ST_START || state_next == ST_SHIFT);
        end
    end

    // ------------------------------------------------------------------------
    // Accumulator and published code. The code is the top four bits of the
    // sum, i.e. the mean truncated to its top four bits. Partial sums survive
    // an enable drop and are only discarded by reset.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc          <= '0;
            sample_cnt   <= '0;
            sensor       <= 4'hF;
            sensor_valid <= 1'b0;
        end else begin
            sensor_valid <= 1'b0;
            if (state == ST_ACCUM) begin
                if (avg_done) begin
                    sensor       <= acc_sum[ACC_W-1 -: 4];
                    sensor_valid <= 1'b1;
                    acc          <= '0;
                    sample_cnt   <= '0;
                end else begin
                    acc        <= acc_sum;
                    sample_cnt <= sample_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_moisture_sensor_frontend.sv
// -----------------------------------------------------------------------------
// Testbench for moisture_sensor_frontend (SAMPLE_PERIOD shortened to 100).
// A behavioural ADC serves words from a queue; a monitor records every cs_n
// low window (start cycle, length, sclk rises) and valid pulses; expected
// codes come from an arithmetic model: floor(mean of 4 words) top four bits.
// -----------------------------------------------------------------------------
module tb_moisture_sensor_frontend;

    localparam int CLK_DIV       = 4;
    localparam int ADC_BITS      = 8;
    localparam int AVG_LOG2      = 2;
    localparam int SAMPLE_PERIOD = 100;
    localparam int N_AVG         = 1 << AVG_LOG2;
    localparam int WIN_LEN       = 2 * CLK_DIV * ADC_BITS + CLK_DIV;
    localparam int CONV_LEN      = 2 * CLK_DIV * (ADC_BITS + 1) + 1;

    logic       clk      = 1'b0;
    logic       reset    = 1'b0;
    logic       enable   = 1'b0;
    logic       adc_miso = 1'b0;
    logic       adc_cs_n;
    logic       adc_sclk;
    logic [3:0] sensor;
    logic       sensor_valid;
    logic       busy;

    int passed = 0;
    int total  = 0;
    int cycle  = 0;

    moisture_sensor_frontend #(
        .CLK_DIV      (CLK_DIV),
        .ADC_BITS     (ADC_BITS),
        .AVG_LOG2     (AVG_LOG2),
        .SAMPLE_PERIOD(SAMPLE_PERIOD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .adc_miso    (adc_miso),
        .adc_cs_n    (adc_cs_n),
        .adc_sclk    (adc_sclk),
        .sensor      (sensor),
        .sensor_valid(sensor_valid),
        .busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    // ---------------------------------------------------------------- ADC model
    int                  word_q[$];
    logic [ADC_BITS-1:0] cur_word   = '0;
    int                  bit_idx    = 0;
    bit                  adc_active = 1'b0;

    always @(negedge adc_cs_n or posedge adc_cs_n or negedge adc_sclk) begin
        if (adc_cs_n !== 1'b0) begin
            adc_active = 1'b0;
        end else if (!adc_active) begin
            adc_active = 1'b1;
            if (word_q.size() > 0) cur_word = ADC_BITS'(word_q.pop_front());
            else                   cur_word = '0;
            bit_idx = ADC_BITS - 1;
        end else if (bit_idx > 0) begin
            bit_idx--;
        end
        adc_miso = cur_word[bit_idx];
    end

    // ------------------------------------------------------------------ monitor
    int         win_start[$];
    int         win_len[$];
    int         win_rises[$];
    bit         in_win      = 1'b0;
    int         cur_len     = 0;
    int         cur_rises   = 0;
    logic       prev_sclk   = 1'b0;
    logic       prev_valid  = 1'b0;
    logic       prev_reset  = 1'b0;
    logic [3:0] prev_sensor = 4'hF;
    int         valid_pulses = 0;
    int         bad_change   = 0;
    int         valid_long   = 0;

    always @(negedge clk) begin
        if (adc_cs_n === 1'b0) begin
            if (!in_win) begin
                in_win    = 1'b1;
                cur_len   = 0;
                cur_rises = 0;
                win_start.push_back(cycle);
            end
            cur_len++;
            if (adc_sclk === 1'b1 && prev_sclk === 1'b0) cur_rises++;
        end else if (in_win) begin
            win_len.push_back(cur_len);
            win_rises.push_back(cur_rises);
            in_win = 1'b0;
        end
        prev_sclk = adc_sclk;
        if (sensor_valid === 1'b1) begin
            valid_pulses++;
            if (prev_valid === 1'b1) valid_long++;
        end
        if (reset === 1'b1 && prev_reset === 1'b1 && sensor !== prev_sensor && sensor_valid !== 1'b1)
            bad_change++;
        prev_valid  = sensor_valid;
        prev_sensor = sensor;
        prev_reset  = reset;
    end

    // ---------------------------------------------------------- reference model
    function automatic logic [3:0] model_code(input int sum);
        int mean;
        mean = sum / N_AVG;
        return 4'(mean / (1 << (ADC_BITS - 4)));
    endfunction

    // ------------------------------------------------------------------ helpers
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_monitor();
        win_start.delete();
        win_len.delete();
        win_rises.delete();
        valid_pulses = 0;
    endtask

    task automatic do_reset();
        tick();
        reset  = 1'b0;
        enable = 1'b0;
        tick();
        word_q.delete();
        reset = 1'b1;
        clear_monitor();
    endtask

    task automatic wait_valid(input int budget, output bit ok, output int at_cycle);
        ok       = 1'b0;
        at_cycle = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (sensor_valid === 1'b1) begin
                ok       = 1'b1;
                at_cycle = cycle;
                break;
            end
        end
    endtask

    task automatic wait_starts(input int k, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (win_start.size() >= k) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_closes(input int k, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (win_len.size() >= k) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // -------------------------------------------------------------------- tests
    task automatic test_reset();
        reset  = 1'b0;
        enable = 1'b0;
        tick();
        tick();
        total++; if (sensor !== 4'hF)     $display("FAIL rst_sensor: got %h expected F", sensor);       else passed++;
        total++; if (sensor_valid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", sensor_valid); else passed++;
        total++; if (adc_cs_n !== 1'b1)   $display("FAIL rst_cs_n: got %b expected 1", adc_cs_n);       else passed++;
        total++; if (adc_sclk !== 1'b0)   $display("FAIL rst_sclk: got %b expected 0", adc_sclk);       else passed++;
        total++; if (busy !== 1'b0)       $display("FAIL rst_busy: got %b expected 0", busy);           else passed++;
        reset = 1'b1;
        clear_monitor();
        repeat (500) tick();
        total++; if (win_start.size() !== 0) $display("FAIL idle_cs_activity: got %0d windows expected 0", win_start.size()); else passed++;
        total++; if (sensor !== 4'hF)        $display("FAIL idle_sensor: got %h expected F", sensor);                        else passed++;
    endtask

    task automatic test_constant();
        bit ok;
        int vcyc;
        do_reset();
        repeat (N_AVG) word_q.push_back('h35);
        enable = 1'b1;
        tick();
        total++; if (adc_cs_n !== 1'b0 || busy !== 1'b1)
            $display("FAIL const_first_start: cs_n=%b busy=%b expected cs_n=0 busy=1", adc_cs_n, busy); else passed++;
        wait_valid(600, ok, vcyc);
        total++; if (ok !== 1'b1) $display("FAIL const_valid_timeout: got none expected a pulse"); else passed++;
        total++; if (sensor !== model_code(N_AVG * 'h35)) $display("FAIL const_code: got %h expected %h", sensor, model_code(N_AVG * 'h35)); else passed++;
        total++; if (win_len.size() !== N_AVG) $display("FAIL const_windows: got %0d expected %0d", win_len.size(), N_AVG); else passed++;
        for (int i = 0; i < win_len.size() && i < N_AVG; i++) begin
            total++; if (win_len[i] !== WIN_LEN)  $display("FAIL const_cs_len[%0d]: got %0d expected %0d", i, win_len[i], WIN_LEN); else passed++;
            total++; if (win_rises[i] !== ADC_BITS) $display("FAIL const_rises[%0d]: got %0d expected %0d", i, win_rises[i], ADC_BITS); else passed++;
        end
        for (int i = 1; i < win_start.size() && i < N_AVG; i++) begin
            total++; if (win_start[i] - win_start[i-1] !== SAMPLE_PERIOD)
                $display("FAIL const_spacing[%0d]: got %0d expected %0d", i, win_start[i] - win_start[i-1], SAMPLE_PERIOD); else passed++;
        end
        if (win_start.size() >= N_AVG) begin
            total++; if (vcyc - win_start[N_AVG-1] !== CONV_LEN)
                $display("FAIL const_latency: got %0d expected %0d", vcyc - win_start[N_AVG-1], CONV_LEN); else passed++;
        end
        tick();
        total++; if (sensor_valid !== 1'b0) $display("FAIL const_valid_width: got %b expected 0", sensor_valid); else passed++;
        total++; if (valid_pulses !== 1)    $display("FAIL const_valid_count: got %0d expected 1", valid_pulses); else passed++;
    endtask

    task automatic run_groups(input string name, input int words[$]);
        bit ok;
        int vcyc;
        int sum;
        int groups;
        logic [3:0] exp;
        do_reset();
        foreach (words[i]) word_q.push_back(words[i]);
        groups = words.size() / N_AVG;
        enable = 1'b1;
        for (int g = 0; g < groups; g++) begin
            sum = 0;
            for (int k = 0; k < N_AVG; k++) sum += words[g * N_AVG + k];
            exp = model_code(sum);
            wait_valid(600, ok, vcyc);
            total++; if (ok !== 1'b1) $display("FAIL %s_timeout[%0d]: got none expected a pulse", name, g); else passed++;
            total++; if (sensor !== exp) $display("FAIL %s_code[%0d]: got %h expected %h", name, g, sensor, exp); else passed++;
            total++; if (win_start.size() !== (g + 1) * N_AVG)
                $display("FAIL %s_per_group[%0d]: got %0d conversions expected %0d", name, g, win_start.size(), (g + 1) * N_AVG); else passed++;
        end
        tick();
        total++; if (valid_pulses !== groups) $display("FAIL %s_valid_count: got %0d expected %0d", name, valid_pulses, groups); else passed++;
    endtask

    task automatic test_ramp();
        int w[$];
        w = '{'h10, 'h30, 'h50, 'h70};
        for (int i = 0; i < N_AVG; i++) w.push_back(int'($urandom_range(0, 255)));
        run_groups("ramp", w);
    endtask

    task automatic test_extremes();
        int w[$];
        w = '{'hFF, 'hFF, 'hFF, 'hFF, 'h0F, 'h0F, 'h0F, 'h0F};
        run_groups("extreme", w);
    endtask

    task automatic test_random();
        int w[$];
        for (int i = 0; i < 3 * N_AVG; i++) w.push_back(int'($urandom_range(0, 255)));
        run_groups("random", w);
    endtask

    task automatic test_enable_drop();
        bit ok;
        int vcyc;
        int sum;
        do_reset();
        sum = 0;
        for (int i = 0; i < N_AVG; i++) begin
            word_q.push_back(int'($urandom_range(0, 255)));
            sum += word_q[i];
        end
        enable = 1'b1;
        wait_starts(2, 300, ok);
        total++; if (ok !== 1'b1) $display("FAIL drop_second_start: got none expected a start"); else passed++;
        repeat (20) tick();
        enable = 1'b0;
        wait_closes(2, 100, ok);
        total++; if (ok !== 1'b1) $display("FAIL drop_finish: got cs_n low expected high"); else passed++;
        if (win_rises.size() >= 2) begin
            total++; if (win_rises[1] !== ADC_BITS) $display("FAIL drop_rises: got %0d expected %0d", win_rises[1], ADC_BITS); else passed++;
        end
        repeat (300) tick();
        total++; if (win_start.size() !== 2) $display("FAIL drop_no_restart: got %0d windows expected 2", win_start.size()); else passed++;
        total++; if (valid_pulses !== 0 || sensor !== 4'hF)
            $display("FAIL drop_partial: got %0d pulses code %h expected 0 pulses code F", valid_pulses, sensor); else passed++;
        enable = 1'b1;
        tick();
        total++; if (adc_cs_n !== 1'b0 || busy !== 1'b1)
            $display("FAIL drop_restart: cs_n=%b busy=%b expected cs_n=0 busy=1", adc_cs_n, busy); else passed++;
        wait_valid(400, ok, vcyc);
        total++; if (ok !== 1'b1) $display("FAIL drop_valid_timeout: got none expected a pulse"); else passed++;
        total++; if (sensor !== model_code(sum)) $display("FAIL drop_code: got %h expected %h", sensor, model_code(sum)); else passed++;
        total++; if (win_start.size() !== N_AVG) $display("FAIL drop_conv_count: got %0d expected %0d", win_start.size(), N_AVG); else passed++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int vcyc;
        int sum;
        do_reset();
        repeat (N_AVG) word_q.push_back('h35);
        word_q.push_back('hAA);
        enable = 1'b1;
        wait_valid(600, ok, vcyc);
        total++; if (sensor !== 4'h3) $display("FAIL rmid_pre_code: got %h expected 3", sensor); else passed++;
        wait_starts(N_AVG + 1, 200, ok);
        repeat (20) tick();
        reset = 1'b0;
        #1;
        total++; if (adc_cs_n !== 1'b1 || adc_sclk !== 1'b0)
            $display("FAIL rmid_pins: cs_n=%b sclk=%b expected cs_n=1 sclk=0", adc_cs_n, adc_sclk); else passed++;
        total++; if (sensor !== 4'hF || busy !== 1'b0)
            $display("FAIL rmid_state: sensor=%h busy=%b expected sensor=F busy=0", sensor, busy); else passed++;
        word_q.delete();
        sum = 0;
        for (int i = 0; i < N_AVG; i++) begin
            word_q.push_back(int'($urandom_range(0, 255)));
            sum += word_q[i];
        end
        tick();
        clear_monitor();
        reset = 1'b1;
        wait_valid(600, ok, vcyc);
        total++; if (ok !== 1'b1) $display("FAIL rmid_valid_timeout: got none expected a pulse"); else passed++;
        total++; if (win_start.size() !== N_AVG) $display("FAIL rmid_fresh_count: got %0d expected %0d", win_start.size(), N_AVG); else passed++;
        total++; if (sensor !== model_code(sum)) $display("FAIL rmid_code: got %h expected %h", sensor, model_code(sum)); else passed++;
    endtask

    task automatic test_stability();
        total++; if (bad_change !== 0) $display("FAIL sensor_stable: got %0d unflagged changes expected 0", bad_change); else passed++;
        total++; if (valid_long !== 0) $display("FAIL valid_one_cycle: got %0d long pulses expected 0", valid_long); else passed++;
    endtask

    initial begin
        test_reset();
        test_constant();
        test_ramp();
        test_extremes();
        test_random();
        test_enable_drop();
        test_reset_mid();
        test_stability();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
